multicycle_controller: RTL and testbench

- Control FSM that sequences a multi-cycle RV32 datapath sharing one unified instruction/data memory with variable latency.
- Sits beside the register file, ALU, extender and PC register. Drives every mux select, write enable and ALU operation per cycle.
- Stalls on a req/ready memory handshake and keeps a retired-instruction counter.

---
 rtl/riscv_ctrl_pkg.sv | 69 ++++++
 rtl/alu_decoder.sv | 29 ++
 rtl/multicycle_controller.sv | 157 +++++++++++++++
 tb/tb_multicycle_controller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 controller: states, opcodes and datapath select codes.
package riscv_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 7;

  typedef enum logic [STATE_W-1:0] {
    S_BOOT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXECR    = 4'd7,
    S_EXECI    = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  // Which ALU decode applies: real decode only while executing R/I ops.
  typedef enum logic {
    CLS_OTHER = 1'b0,
    CLS_EXEC  = 1'b1
  } alu_cls_t;

  localparam logic [OP_W-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R     = 7'b0110011;
  localparam logic [OP_W-1:0] OP_I     = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BR    = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src(input logic [OP_W-1:0] op);
    case (op)
      OP_STORE: imm_src = IMM_S;
      OP_BR:    imm_src = IMM_B;
      OP_JAL:   imm_src = IMM_J;
      default:  imm_src = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode for R/I execute states; flags funct3 values the datapath does not support.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  alu_cls_t   cls,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control,
  output logic       bad_funct
);

  always_comb begin
    alu_control = ALU_ADD;
    bad_funct   = 1'b0;
    if (cls == CLS_EXEC) begin
      case (funct3)
        // op bit 5 separates R-type (sub allowed) from I-type (addi ignores bit 30)
        3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
        3'b010:  alu_control = ALU_SLT;
        3'b100:  alu_control = ALU_XOR;
        3'b110:  alu_control = ALU_OR;
        3'b111:  alu_control = ALU_AND;
        default: bad_funct   = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32 control FSM: sequences the shared-memory datapath, stalls on mem_ready,
// counts retired instructions.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             Sign,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUControl,
  output logic [1:0]       ImmSrc,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t     state, state_nxt;
  alu_cls_t   alu_cls;
  logic [2:0] dec_alu;
  logic       bad_funct;
  logic       retire;

  assign alu_cls = (state == S_EXECR || state == S_EXECI) ? CLS_EXEC : CLS_OTHER;

  alu_decoder u_alu_decoder (
    .cls        (alu_cls),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .op5        (op[5]),
    .alu_control(dec_alu),
    .bad_funct  (bad_funct)
  );

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) state <= S_BOOT;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset)     instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end

  // Next state and per-state datapath controls
  always_comb begin
    state_nxt  = state;
    retire     = 1'b0;
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ALUControl = ALU_ADD;
    ImmSrc     = imm_src(op);
    illegal    = 1'b0;

    case (state)
      S_BOOT: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
        if (mem_ready) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_R:              state_nxt = S_EXECR;
          OP_I:              state_nxt = S_EXECI;
          OP_BR:             state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          default:           state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        state_nxt = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_MEM;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = (state == S_EXECR) ? SRCB_RS2 : SRCB_IMM;
        ALUControl = dec_alu;
        state_nxt  = bad_funct ? S_TRAP : S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        ALUControl = ALU_SUB;
        case (funct3)
          3'b000:  PCWrite = Zero;
          3'b001:  PCWrite = !Zero;
          3'b100:  PCWrite = Sign;
          default: PCWrite = 1'b0;
        endcase
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        PCWrite   = 1'b1;
        state_nxt = S_ALUWB;
      end
      S_TRAP: illegal = 1'b1;
      default: state_nxt = S_TRAP;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven cycle checks of multicycle_controller with a scoreboard queue; a 2-bit counter
// instance shares the stimulus to exercise instret wrap-around.
module tb_multicycle_controller;

  localparam logic [6:0] LW = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011;
  localparam logic [6:0] RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] JL = 7'b1101111;
  localparam logic [6:0] XX = 7'b1111111;

  // {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal}
  typedef struct packed {
    logic [5:0] flags;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] alu;
    logic [1:0] imm;
    logic       ill;
  } outs_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic       s;
    logic       rdy;
    outs_t      exp;
    logic       ret;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        areset, funct7b5, Zero, Sign, mem_ready;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [31:0] instret;
  logic        s_mem_req, s_MemWrite, s_AdrSrc, s_IRWrite, s_PCWrite, s_RegWrite, s_illegal;
  logic [1:0]  s_ResultSrc, s_ALUSrcA, s_ALUSrcB, s_ImmSrc;
  logic [2:0]  s_ALUControl;
  logic [1:0]  s_instret;

  multicycle_controller u_dut (
    .clk(clk), .areset(areset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Sign(Sign), .mem_ready(mem_ready), .mem_req(mem_req),
    .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal), .instret(instret)
  );

  multicycle_controller #(.CNT_W(2)) u_small (
    .clk(clk), .areset(areset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Sign(Sign), .mem_ready(mem_ready), .mem_req(s_mem_req),
    .MemWrite(s_MemWrite), .AdrSrc(s_AdrSrc), .IRWrite(s_IRWrite), .PCWrite(s_PCWrite),
    .RegWrite(s_RegWrite), .ResultSrc(s_ResultSrc), .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB),
    .ALUControl(s_ALUControl), .ImmSrc(s_ImmSrc), .illegal(s_illegal), .instret(s_instret)
  );

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_cnt = 32'd0;
  vec_t        tbl[$];
  vec_t        sb[$];

  function automatic outs_t mk(input logic [5:0] flags, input logic [1:0] rs, input logic [1:0] sa,
                               input logic [1:0] sbs, input logic [2:0] alu, input logic [1:0] imm,
                               input logic ill);
    mk = {flags, rs, sa, sbs, alu, imm, ill};
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    case (o)
      SW:      imm_of = 2'b01;
      BR:      imm_of = 2'b10;
      JL:      imm_of = 2'b11;
      default: imm_of = 2'b00;
    endcase
  endfunction

  task automatic put(input string n, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input logic z, input logic s, input logic rdy, input outs_t e, input logic ret);
    vec_t v;
    v.name = n; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.s = s; v.rdy = rdy; v.exp = e; v.ret = ret;
    tbl.push_back(v);
  endtask

  task automatic fetch_decode(input string n, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                              input logic z, input logic s, input int stalls);
    for (int i = 0; i < stalls; i++)
      put({n, "_fetch_wait"}, o, f3, f7, z, s, 1'b0, mk(6'b100000, 2'b10, 2'b00, 2'b10, 3'b000, imm_of(o), 1'b0), 1'b0);
    put({n, "_fetch"}, o, f3, f7, z, s, 1'b1, mk(6'b100110, 2'b10, 2'b00, 2'b10, 3'b000, imm_of(o), 1'b0), 1'b0);
    put({n, "_decode"}, o, f3, f7, z, s, 1'b1, mk(6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, imm_of(o), 1'b0), 1'b0);
  endtask

  task automatic ins_lw(input int fstall, input int mstall);
    fetch_decode("lw", LW, 3'b010, 1'b0, 1'b0, 1'b0, fstall);
    put("lw_memadr", LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, mk(6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0), 1'b0);
    for (int i = 0; i < mstall; i++)
      put("lw_memread_wait", LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, mk(6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0), 1'b0);
    put("lw_memread", LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, mk(6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0), 1'b0);
    put("lw_memwb", LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, mk(6'b000001, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0), 1'b1);
  endtask

  task automatic ins_sw(input int mstall);
    fetch_decode("sw", SW, 3'b010, 1'b0, 1'b0, 1'b0, 0);
    put("sw_memadr", SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, mk(6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 1'b0), 1'b0);
    for (int i = 0; i < mstall; i++)
      put("sw_memwrite_wait", SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, mk(6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0), 1'b0);
    put("sw_memwrite", SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, mk(6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0), 1'b1);
  endtask

  task automatic ins_alu(input string n, input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic [2:0] alu);
    fetch_decode(n, o, f3, f7, 1'b0, 1'b0, 0);
    put({n, "_exec"}, o, f3, f7, 1'b0, 1'b0, 1'b1,
        mk(6'b000000, 2'b00, 2'b10, (o == RT) ? 2'b00 : 2'b01, alu, imm_of(o), 1'b0), 1'b0);
    put({n, "_aluwb"}, o, f3, f7, 1'b0, 1'b0, 1'b1, mk(6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, imm_of(o), 1'b0), 1'b1);
  endtask

  task automatic ins_br(input string n, input logic [2:0] f3, input logic z, input logic s, input logic pcw);
    fetch_decode(n, BR, f3, 1'b0, z, s, 0);
    put({n, "_branch"}, BR, f3, 1'b0, z, s, 1'b1,
        mk({4'b0000, pcw, 1'b0}, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 1'b0), 1'b1);
  endtask

  task automatic ins_jal();
    fetch_decode("jal", JL, 3'b000, 1'b0, 1'b1, 1'b0, 0);
    put("jal_jal", JL, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, mk(6'b000010, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 1'b0), 1'b0);
    put("jal_aluwb", JL, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, mk(6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11, 1'b0), 1'b1);
  endtask

  task automatic chk_now(input string n, input outs_t e);
    outs_t got;
    got = {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, illegal};
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s outputs got=%05h want=%05h", n, got, e);
    end
    total++;
    if (instret !== exp_cnt) begin
      bad++;
      $display("FAIL %s instret got=%0d want=%0d", n, instret, exp_cnt);
    end
    total++;
    if (s_instret !== exp_cnt[1:0]) begin
      bad++;
      $display("FAIL %s instret_w2 got=%0d want=%0d", n, s_instret, exp_cnt[1:0]);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare at the falling edge.
  task automatic drive(input vec_t v);
    vec_t r;
    op = v.op; funct3 = v.f3; funct7b5 = v.f7; Zero = v.z; Sign = v.s; mem_ready = v.rdy;
    sb.push_back(v);
    @(negedge clk);
    r = sb.pop_front();
    chk_now(r.name, r.exp);
    if (r.ret) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);
    tbl.delete();
  endtask

  task automatic do_reset(input string n);
    areset = 1'b0;
    #1;
    exp_cnt = 32'd0;
    chk_now(n, mk(6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, imm_of(op), 1'b0));
    @(posedge clk);
    #1;
    areset = 1'b1;
  endtask

  initial begin
    areset = 1'b0; op = LW; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0; Sign = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_now("reset_hold", mk(6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0));
    areset = 1'b1;

    put("boot", LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, mk(6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0), 1'b0);
    ins_lw(3, 2);
    ins_alu("sub", RT, 3'b000, 1'b1, 3'b001);
    ins_br("beq_taken", 3'b000, 1'b1, 1'b0, 1'b1);
    ins_sw(5);
    ins_br("bne_nt", 3'b001, 1'b1, 1'b0, 1'b0);
    ins_br("blt_taken", 3'b100, 1'b0, 1'b1, 1'b1);
    ins_br("beq_nt", 3'b000, 1'b0, 1'b1, 1'b0);
    ins_br("bge_unsup", 3'b101, 1'b1, 1'b1, 1'b0);
    ins_jal();
    ins_alu("add", RT, 3'b000, 1'b0, 3'b000);
    ins_alu("addi_b30", IT, 3'b000, 1'b1, 3'b000);
    ins_alu("slti", IT, 3'b010, 1'b0, 3'b101);
    ins_alu("xori", IT, 3'b100, 1'b0, 3'b100);
    ins_alu("or", RT, 3'b110, 1'b0, 3'b011);
    ins_alu("and", RT, 3'b111, 1'b1, 3'b010);
    run_table();

    // Illegal opcode: trap absorbs, no memory requests even with mem_ready high.
    fetch_decode("illop", XX, 3'b000, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++)
      put("illop_trap", XX, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, mk(6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1), 1'b0);
    run_table();
    do_reset("trap_reset");
    put("boot2", RT, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, mk(6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0), 1'b0);

    // Unsupported R funct3 traps after execute without retiring.
    fetch_decode("sll", RT, 3'b001, 1'b0, 1'b0, 1'b0, 1);
    put("sll_exec", RT, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, mk(6'b000000, 2'b00, 2'b10, 2'b00, 3'b000, 2'b00, 1'b0), 1'b0);
    for (int i = 0; i < 2; i++)
      put("sll_trap", RT, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, mk(6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1), 1'b0);
    run_table();
    do_reset("trap_reset2");

    // Reset in the middle of a stalled load drops mem_req immediately.
    put("boot3", LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, mk(6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0), 1'b0);
    fetch_decode("lw2", LW, 3'b010, 1'b0, 1'b0, 1'b0, 1);
    put("lw2_memadr", LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, mk(6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0), 1'b0);
    put("lw2_memread_wait", LW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, mk(6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0), 1'b0);
    run_table();
    #2;
    do_reset("midaccess_reset");
    put("boot4", SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1, mk(6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0), 1'b0);
    ins_sw(1);
    put("post_sw_fetch", SW, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, mk(6'b100000, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 1'b0), 1'b0);
    run_table();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
